uart_sram_loader: RTL

// - Parametrised UART-to-SRAM loader: strips a configurable number of LF-terminated header lines,

---
 rtl/uart_sram_pkg.sv | 16 +
 rtl/uart_sram_loader_rx.sv | 102 ++++++++++
 rtl/uart_sram_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_sram_pkg.sv
// uart_sram_pkg: shared loader state encoding, ASCII constants and word sizing helper.
package uart_sram_pkg;
  typedef enum logic [2:0] {
    IDLE,
    HDR_WAIT,
    HDR_ACK,
    BYTE_WAIT,
    BYTE_ACK,
    WRITE,
    DONE
  } loader_state_e;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  function automatic int BYTES_PER_WORD(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/uart_sram_loader_rx.sv
// UART_receive_controller: 8N1 receiver with a one-byte holding register and Empty/Unload handshake.
module UART_receive_controller #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Clear,
  input  logic       Enable,
  input  logic       Unload,
  input  logic       UART_RX_I,
  output logic [7:0] RX_data,
  output logic       Empty,
  output logic       Frame_error,
  output logic       Overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_phase_e;
  rx_phase_e phase_q, phase_d;
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic empty_q, empty_d, fe_q, fe_d, ov_q, ov_d;
  logic rx;
  assign rx = sync_q[1];
  always_comb begin
    sync_d = {sync_q[0], UART_RX_I};
    phase_d = phase_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    empty_d = empty_q | Unload;
    fe_d = fe_q;
    ov_d = ov_q;
    case (phase_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx) phase_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        phase_d = rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        shift_d = {rx, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) phase_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        phase_d = RX_IDLE;
        fe_d = !rx;
        // a byte landing while the previous one is still held is dropped and flagged
        if (Enable && !empty_d) ov_d = 1'b1;
        else if (Enable) begin
          data_d = shift_q;
          empty_d = 1'b0;
        end
      end
      default: phase_d = RX_IDLE;
    endcase
    if (Clear) begin
      phase_d = RX_IDLE;
      cnt_d = '0;
      data_d = '0;
      empty_d = 1'b1;
      fe_d = 1'b0;
      ov_d = 1'b0;
    end
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      sync_q <= 2'b11;
      phase_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      empty_q <= 1'b1;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      empty_q <= empty_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  assign RX_data = data_q;
  assign Empty = empty_q;
  assign Frame_error = fe_q;
  assign Overrun = ov_q;
endmodule

// File: rtl/uart_sram_loader.sv
// uart_sram_loader: strips LF-terminated header lines, packs UART bytes MSB-first into SRAM words.
// Define UART_SRAM_LOADER_CHECKSUM_EN to add the 16-bit payload byte-sum output Checksum.
module uart_sram_loader
  import uart_sram_pkg::*;
#(
  parameter int          ADDR_W       = 18,
  parameter int          DATA_W       = 16,
  parameter int          HEADER_LINES = 3,
  parameter int unsigned ADDR_MAX     = 2**18 - 1,
  parameter int          CLKS_PER_BIT = 434
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              UART_RX_I,
  input  logic              Initialize,
  input  logic              Enable,
  input  logic [ADDR_W-1:0] Base_address,
  input  logic [ADDR_W-1:0] Word_limit,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Words_written,
  output logic              Frame_error,
  output logic              Overrun
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       Checksum
`endif
);
  localparam logic [ADDR_W-1:0] AMAX = ADDR_W'(ADDR_MAX);
  localparam logic [1:0] K_LAST = 2'(BYTES_PER_WORD(DATA_W) - 1);
  localparam logic [7:0] HL = 8'(HEADER_LINES);
  loader_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, limit_q, limit_d, words_q, words_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0] lf_q, lf_d, rx_data;
  logic [1:0] k_q, k_d;
  logic we_n_q, we_n_d, done_q, done_d, busy_q, busy_d;
  logic rx_en_q, rx_en_d, unload_q, unload_d, rx_empty;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif
  UART_receive_controller #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .Clock(Clock), .Resetn(Resetn), .Clear(Initialize), .Enable(rx_en_q), .Unload(unload_q),
    .UART_RX_I(UART_RX_I), .RX_data(rx_data), .Empty(rx_empty), .Frame_error(Frame_error),
    .Overrun(Overrun)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    limit_d = limit_q;
    words_d = words_q;
    data_d = data_q;
    lf_d = lf_q;
    k_d = k_q;
    we_n_d = 1'b1;
    done_d = 1'b0;
    rx_en_d = rx_en_q;
    unload_d = unload_q;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (Initialize) begin
      state_d = IDLE;
      addr_d = '0;
      limit_d = '0;
      words_d = '0;
      data_d = '0;
      lf_d = '0;
      k_d = '0;
      rx_en_d = 1'b0;
      unload_d = 1'b0;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
      csum_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: if (Enable) begin
          addr_d = (Base_address > AMAX) ? AMAX : Base_address;
          limit_d = Word_limit;
          words_d = '0;
          lf_d = '0;
          k_d = '0;
          rx_en_d = 1'b1;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
          csum_d = '0;
`endif
          state_d = (HEADER_LINES > 0) ? HDR_WAIT : BYTE_WAIT;
        end
        HDR_WAIT: if (!rx_empty) begin
          unload_d = 1'b1;
          state_d = HDR_ACK;
          if (rx_data == ASCII_LF && lf_q != HL) lf_d = lf_q + 8'd1;
        end
        HDR_ACK: if (rx_empty) begin
          unload_d = 1'b0;
          state_d = (lf_q == HL) ? BYTE_WAIT : HDR_WAIT;
        end
        BYTE_WAIT: if (!rx_empty) begin
          unload_d = 1'b1;
          state_d = BYTE_ACK;
          data_d[DATA_W - 1 - 8 * int'(k_q) -: 8] = rx_data;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
          csum_d = csum_q + {8'h00, rx_data};
`endif
        end
        BYTE_ACK: if (rx_empty) begin
          unload_d = 1'b0;
          state_d = (k_q == K_LAST) ? WRITE : BYTE_WAIT;
          we_n_d = (k_q != K_LAST);
          k_d = (k_q == K_LAST) ? k_q : k_q + 2'd1;
        end
        WRITE: begin
          words_d = words_q + ADDR_W'(1);
          k_d = '0;
          // the ceiling check keeps the address from ever stepping past ADDR_MAX
          if ((limit_q != '0 && words_q + ADDR_W'(1) == limit_q) || addr_q == AMAX) begin
            state_d = DONE;
            done_d = 1'b1;
            rx_en_d = 1'b0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            state_d = BYTE_WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state_q <= IDLE;
      addr_q <= '0;
      limit_q <= '0;
      words_q <= '0;
      data_q <= '0;
      lf_q <= '0;
      k_q <= '0;
      we_n_q <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      rx_en_q <= 1'b0;
      unload_q <= 1'b0;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      limit_q <= limit_d;
      words_q <= words_d;
      data_q <= data_d;
      lf_q <= lf_d;
      k_q <= k_d;
      we_n_q <= we_n_d;
      done_q <= done_d;
      busy_q <= busy_d;
      rx_en_q <= rx_en_d;
      unload_q <= unload_d;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  assign SRAM_address = addr_q;
  assign SRAM_write_data = data_q;
  assign SRAM_we_n = we_n_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Words_written = words_q;
`ifdef UART_SRAM_LOADER_CHECKSUM_EN
  assign Checksum = csum_q;
`endif
endmodule
